// File: rtl/fp_addsub_dispatcher.sv
// Command front-end for the FP add/sub unit: queues operand commands, issues them one
// at a time with a start pulse, and returns each result (or a watchdog NaN) on a valid/ready port.
module fp_addsub_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic                   res_timeout,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   fpu_start,
  output logic                   fpu_op,
  output logic [31:0]            fpu_data_a,
  output logic [31:0]            fpu_data_b,
  input  logic                   fpu_busy,
  input  logic                   fpu_ready,
  input  logic [31:0]            fpu_data_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_t;

  cmd_t              mem_q [DEPTH];
  cmd_t              cmd_in;
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, full, empty;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  cmd_t              iss_q, iss_d;
  logic              start_q, start_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_to_q, res_to_d;

  // Busy is informational only; the handshake relies on start/ready.
  logic unused_busy;
  assign unused_busy = fpu_busy;

  assign cmd_in = {cmd_op, cmd_a, cmd_b};
  assign head   = mem_q[rd_ptr_q];
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign push   = cmd_valid & ~full;

  // FIFO bookkeeping; a full FIFO refuses pushes even when popping the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Issue FSM: one command in flight, watchdog bounds the wait for the adder.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    iss_d       = iss_q;
    start_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_to_d    = res_to_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          iss_d   = head;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (fpu_ready) begin
          res_data_d  = fpu_data_o;
          res_to_d    = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          res_data_d  = QNAN;
          res_to_d    = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wd_q        <= '0;
      iss_q       <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      iss_q       <= iss_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_to_q    <= res_to_d;
    end
  end

  assign cmd_ready   = ~full;
  assign pending     = count_q;
  assign fpu_start   = start_q;
  assign fpu_op      = iss_q.op;
  assign fpu_data_a  = iss_q.a;
  assign fpu_data_b  = iss_q.b;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_to_q;

endmodule

// File: tb/tb_fp_addsub_dispatcher.sv
// Bench for fp_addsub_dispatcher: a stub adder answers start pulses, a queue holds expected results.
module tb_fp_addsub_dispatcher;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  logic        clock, reset;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        res_valid, res_ready, res_timeout;
  logic [31:0] res_data;
  logic [$clog2(DEPTH):0] pending;
  logic        fpu_start, fpu_op, fpu_busy, fpu_ready;
  logic [31:0] fpu_data_a, fpu_data_b, fpu_data_o;

  typedef struct {
    logic [31:0] data;
    logic        to;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // stub adder state
  bit          stub_en  = 1'b1;
  int          stub_lat = 3;
  int          stub_cnt = 0;
  logic        stub_op;
  logic [31:0] stub_a, stub_b;
  int          start_cnt = 0;
  int          hold_viol = 0;
  int          dbl_start = 0;
  bit          prev_start = 1'b0;
  int          spur_req = 0;
  int          spur_done = 0;

  fp_addsub_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .pending(pending),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_data_a(fpu_data_a),
    .fpu_data_b(fpu_data_b), .fpu_busy(fpu_busy), .fpu_ready(fpu_ready),
    .fpu_data_o(fpu_data_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Known IEEE sums/differences; anything else gets an arbitrary but distinct pattern.
  function automatic logic [31:0] fpu_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
      {1'b1, 32'h3F800000, 32'h40000000}: return 32'hBF800000;
      {1'b0, 32'h3FC00000, 32'h3F000000}: return 32'h40000000;
      default: return a ^ b ^ {31'b0, op};
    endcase
  endfunction

  // Stub adder: responds stub_lat cycles after a start, checks operands stay put meanwhile.
  always @(negedge clock) begin
    fpu_ready  = 1'b0;
    fpu_data_o = 32'h0;
    if (reset) begin
      stub_cnt   = 0;
      prev_start = 1'b0;
    end else begin
      if (stub_cnt != 0) begin
        if (fpu_op !== stub_op || fpu_data_a !== stub_a || fpu_data_b !== stub_b) hold_viol++;
        stub_cnt--;
        if (stub_cnt == 0) begin
          fpu_ready  = 1'b1;
          fpu_data_o = fpu_model(stub_op, stub_a, stub_b);
        end
      end
      if (fpu_start === 1'b1) begin
        start_cnt++;
        if (prev_start) dbl_start++;
        if (stub_en) begin
          stub_cnt = stub_lat;
          stub_op  = fpu_op;
          stub_a   = fpu_data_a;
          stub_b   = fpu_data_b;
        end
      end
      prev_start = (fpu_start === 1'b1);
      if (spur_req != spur_done) begin
        spur_done++;
        fpu_ready  = 1'b1;
        fpu_data_o = 32'hDEADBEEF;
      end
    end
    fpu_busy = (stub_cnt != 0);
  end

  // Offer one command until accepted; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    exp_t e;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clock);
    cmd_valid = 1'b0;
    if (stub_en) begin e.data = fpu_model(op, a, b); e.to = 1'b0; end
    else begin e.data = QNAN; e.to = 1'b1; end
    exp_q.push_back(e);
  endtask

  // Wait for a result and accept it; no checking here.
  task automatic consume(output logic [31:0] d, output logic t, output bit ok);
    int n = 0;
    while (res_valid !== 1'b1 && n < 500) begin
      @(negedge clock);
      n++;
    end
    ok = (res_valid === 1'b1);
    d  = res_data;
    t  = res_timeout;
    if (ok) begin
      res_ready = 1'b1;
      @(negedge clock);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; res_ready = 0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (res_valid !== 1'b0 || res_timeout !== 1'b0 || res_data !== 32'h0) begin
      bad++; $display("FAIL rst_result: valid=%b to=%b data=%h, required 0 0 00000000", res_valid, res_timeout, res_data);
    end
    total++; if (pending !== '0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_fifo: pending=%0d cmd_ready=%b, required 0 1", pending, cmd_ready);
    end
    total++; if (fpu_start !== 1'b0 || fpu_op !== 1'b0 || fpu_data_a !== 32'h0 || fpu_data_b !== 32'h0) begin
      bad++; $display("FAIL rst_fpu: start=%b op=%b a=%h b=%h, required all 0", fpu_start, fpu_op, fpu_data_a, fpu_data_b);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [31:0] d; logic t; bit ok; exp_t e; int s0; int n;
    s0 = start_cnt;
    send_cmd(1'b0, 32'h3F800000, 32'h40000000);
    total++; if (fpu_start !== 1'b0) begin
      bad++; $display("FAIL single_start_k1: fpu_start=%b, required 0", fpu_start);
    end
    @(negedge clock);
    total++; if (fpu_start !== 1'b1 || fpu_data_a !== 32'h3F800000 || fpu_data_b !== 32'h40000000 || fpu_op !== 1'b0) begin
      bad++; $display("FAIL single_start_k2: start=%b a=%h b=%h op=%b, required 1 3f800000 40000000 0", fpu_start, fpu_data_a, fpu_data_b, fpu_op);
    end
    @(negedge clock);
    total++; if (fpu_start !== 1'b0) begin
      bad++; $display("FAIL single_start_k3: fpu_start=%b, required 0", fpu_start);
    end
    n = 0;
    do begin @(negedge clock); #1; n++; end while (fpu_ready !== 1'b1 && n < 50);
    total++; if (fpu_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL single_ready_cycle: fpu_ready=%b res_valid=%b, required 1 0", fpu_ready, res_valid);
    end
    @(negedge clock);
    total++; if (res_valid !== 1'b1) begin
      bad++; $display("FAIL single_valid_next: res_valid=%b, required 1", res_valid);
    end
    consume(d, t, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== 32'h40400000 || t !== 1'b0 || e.data !== d) begin
      bad++; $display("FAIL single_result: ok=%0b data=%h to=%b, required 1 40400000 0", ok, d, t);
    end
    @(negedge clock);
    total++; if (pending !== '0 || res_valid !== 1'b0 || start_cnt - s0 != 1) begin
      bad++; $display("FAIL single_after: pending=%0d valid=%b starts=%0d, required 0 0 1", pending, res_valid, start_cnt - s0);
    end
  endtask

  task automatic test_hold();
    logic [31:0] d; logic t; bit ok; exp_t e;
    hold_viol = 0;
    send_cmd(1'b1, 32'h40400000, 32'h3F800000);
    consume(d, t, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== 32'h40000000 || t !== e.to) begin
      bad++; $display("FAIL hold_result: ok=%0b data=%h to=%b, required 1 40000000 0", ok, d, t);
    end
    total++; if (hold_viol != 0) begin
      bad++; $display("FAIL hold_operands: changes=%0d, required 0", hold_viol);
    end
    @(negedge clock);
    total++; if (fpu_op !== 1'b1 || fpu_data_a !== 32'h40400000 || fpu_data_b !== 32'h3F800000) begin
      bad++; $display("FAIL hold_idle: op=%b a=%h b=%h, required 1 40400000 3f800000", fpu_op, fpu_data_a, fpu_data_b);
    end
  endtask

  task automatic test_fill();
    logic [31:0] d; logic t; bit ok; exp_t e; int s0;
    logic        ops [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] as  [5] = '{32'h3F800000, 32'h12345678, 32'h3F800000, 32'h40000000, 32'hCAFEF00D};
    logic [31:0] bs  [5] = '{32'h40000000, 32'h0F0F0F0F, 32'h40000000, 32'h40000000, 32'h00FF00FF};
    s0 = start_cnt;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(ops[i], as[i], bs[i]);
    total++; if (cmd_ready !== 1'b0 || pending !== 3'(DEPTH)) begin
      bad++; $display("FAIL fill_full: cmd_ready=%b pending=%0d, required 0 %0d", cmd_ready, pending, DEPTH);
    end
    for (int i = 0; i < 5; i++) begin
      consume(d, t, ok);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++; $display("FAIL fill_res%0d: ok=%0b queued=%0d, required result present", i, ok, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (d !== e.data || t !== e.to) begin
          bad++; $display("FAIL fill_res%0d: data=%h to=%b, required %h %b", i, d, t, e.data, e.to);
        end
      end
    end
    repeat (3) @(negedge clock);
    total++; if (pending !== '0 || exp_q.size() != 0 || start_cnt - s0 != 5 || dbl_start != 0) begin
      bad++; $display("FAIL fill_end: pending=%0d left=%0d starts=%0d dbl=%0d, required 0 0 5 0", pending, exp_q.size(), start_cnt - s0, dbl_start);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d; logic t; bit ok; exp_t e; int n;
    stub_en = 1'b0;
    send_cmd(1'b0, 32'h3F800000, 32'h40000000);
    n = 0;
    while (fpu_start !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    total++; if (n != TIMEOUT + 1) begin
      bad++; $display("FAIL timeout_latency: cycles=%0d, required %0d", n, TIMEOUT + 1);
    end
    stub_en = 1'b1;
    consume(d, t, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== 32'h7FC00000 || t !== 1'b1 || e.to !== 1'b1) begin
      bad++; $display("FAIL timeout_result: ok=%0b data=%h to=%b, required 1 7fc00000 1", ok, d, t);
    end
    send_cmd(1'b1, 32'h3F800000, 32'h40000000);
    consume(d, t, ok);
    e = exp_q.pop_front();
    total++; if (!ok || d !== 32'hBF800000 || t !== 1'b0 || e.data !== d) begin
      bad++; $display("FAIL timeout_recover: ok=%0b data=%h to=%b, required 1 bf800000 0", ok, d, t);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic t; bit ok; exp_t e; int n; int s0; int viol;
    res_ready = 1'b0;
    send_cmd(1'b0, 32'h3FC00000, 32'h3F000000);
    n = 0;
    while (res_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    s0 = start_cnt;
    send_cmd(1'b0, 32'h40000000, 32'h40000000);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) spur_req++;
      @(negedge clock);
      if (res_valid !== 1'b1 || res_data !== 32'h40000000 || res_timeout !== 1'b0) viol++;
    end
    total++; if (viol != 0) begin
      bad++; $display("FAIL bp_stable: changed cycles=%0d, required 0", viol);
    end
    total++; if (start_cnt != s0 || pending !== 3'd1) begin
      bad++; $display("FAIL bp_no_start: starts=%0d pending=%0d, required 0 1", start_cnt - s0, pending);
    end
    for (int i = 0; i < 2; i++) begin
      consume(d, t, ok);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++; $display("FAIL bp_res%0d: ok=%0b queued=%0d, required result present", i, ok, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (d !== e.data || t !== e.to) begin
          bad++; $display("FAIL bp_res%0d: data=%h to=%b, required %h %b", i, d, t, e.data, e.to);
        end
      end
    end
    s0 = start_cnt;
    spur_req++;
    repeat (4) @(negedge clock);
    total++; if (res_valid !== 1'b0 || start_cnt != s0) begin
      bad++; $display("FAIL bp_idle_spurious: res_valid=%b starts=%0d, required 0 0", res_valid, start_cnt - s0);
    end
  endtask

  task automatic test_reset_in_wait();
    int s0;
    stub_en = 1'b0;
    send_cmd(1'b0, 32'h11111111, 32'h22222222);
    send_cmd(1'b1, 32'h33333333, 32'h44444444);
    send_cmd(1'b0, 32'h55555555, 32'h66666666);
    total++; if (pending !== 3'd2 || fpu_data_a !== 32'h11111111) begin
      bad++; $display("FAIL rw_before: pending=%0d a=%h, required 2 11111111", pending, fpu_data_a);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++; if (pending !== '0 || res_valid !== 1'b0 || fpu_start !== 1'b0 || fpu_op !== 1'b0 ||
                 fpu_data_a !== 32'h0 || fpu_data_b !== 32'h0 || res_data !== 32'h0 || res_timeout !== 1'b0) begin
      bad++; $display("FAIL rw_reset: pending=%0d valid=%b start=%b op=%b a=%h b=%h data=%h to=%b, required all 0",
                      pending, res_valid, fpu_start, fpu_op, fpu_data_a, fpu_data_b, res_data, res_timeout);
    end
    reset = 1'b0;
    exp_q.delete();
    s0 = start_cnt;
    repeat (80) @(negedge clock);
    total++; if (start_cnt != s0 || res_valid !== 1'b0 || pending !== '0) begin
      bad++; $display("FAIL rw_after: starts=%0d valid=%b pending=%0d, required 0 0 0", start_cnt - s0, res_valid, pending);
    end
    stub_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 0; res_ready = 0;
    @(negedge clock);
    test_reset();
    test_single();
    test_hold();
    test_fill();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1);
  end

endmodule
